// File: rtl/demod_pkg.sv
// Shared types for the demodulator front end: sample, channel id,
// the tagged beat carried between arbiter and demod, and the arbiter FSM.
package demod_pkg;

    localparam int DW = 24;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic [1:0]           ch_id_t;

    typedef struct packed {
        sample_t d;
        ch_id_t  id;
        logic    last;
    } beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    // First set bit of mask, searched cyclically upward from start.
    // Returns start when the mask is empty.
    function automatic ch_id_t first_from(
        input logic [3:0] mask,
        input ch_id_t     start
    );
        ch_id_t idx;
        ch_id_t res;
        logic   found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + ch_id_t'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice for a valid/ready stream of any packed type.
// Ports: i_clk, i_rst_n (async, active-low); i_data/i_valid in, o_room
// (fewer than two entries held, registered); o_data/o_valid/i_ready out.
module axis_skid_buf
    import demod_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  T     i_data,
    input  logic i_valid,
    output logic o_room,
    output T     o_data,
    output logic o_valid,
    input  logic i_ready
);

    logic [1:0] r_cnt;
    T           r_q0;
    T           r_q1;
    logic       w_pop;
    logic       w_push;

    // Room depends only on stored occupancy, so upstream ready never
    // sees the downstream ready combinationally.
    assign o_room  = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_q0;

    assign w_pop  = o_valid & i_ready;
    assign w_push = i_valid & (o_room | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 2'd0;
            r_q0  <= '0;
            r_q1  <= '0;
        end else begin
            unique case (r_cnt)
                2'd0: begin
                    if (w_push) begin
                        r_q0  <= i_data;
                        r_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_q0 <= i_data;
                    end else if (w_push) begin
                        r_q1  <= i_data;
                        r_cnt <= 2'd2;
                    end else if (w_pop) begin
                        r_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_q0 <= r_q1;
                        if (w_push) begin
                            r_q1 <= i_data;
                        end else begin
                            r_cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/demod_ch_arbiter.sv
// Merges NCH per-channel sample streams into one demod stream tagged with
// the channel id (tuser), marking round ends with tlast and counting rounds.
// Ports: s_axis_* per-channel inputs, ch_en enable mask, m_axis_* merged
// output, round_cnt completed rounds. Async active-low s_axis_aresetn.
module demod_ch_arbiter
    import demod_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int DW     = demod_pkg::DW,
    parameter bit STRICT = 1'b1
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*DW-1:0] s_axis_tdata,
    input  logic [NCH-1:0]    s_axis_tvalid,
    output logic [NCH-1:0]    s_axis_tready,
    output logic [DW-1:0]     m_axis_tdata,
    output logic [1:0]        m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       round_cnt
);

    arb_state_t     r_state;
    arb_state_t     w_state_nx;
    ch_id_t         r_ptr;
    ch_id_t         w_ptr_nx;
    logic [NCH-1:0] r_en_q;
    logic [NCH-1:0] w_en_nx;
    logic [31:0]    r_round_cnt;

    logic [3:0]     w_en4;
    logic [3:0]     w_ch_en4;
    logic [3:0]     w_vld4;
    logic [3:0]     w_rdy4;
    ch_id_t         w_grant;
    ch_id_t         w_next;
    logic           w_gvalid;
    logic           w_room;
    logic           w_accept;
    logic           w_last;
    logic [DW-1:0]  w_sel;
    beat_t          w_beat;
    beat_t          w_out;
    logic           w_out_valid;

    // Work on 4-bit views so channel ids can index without range games.
    assign w_en4    = 4'(r_en_q);
    assign w_ch_en4 = 4'(ch_en);
    assign w_vld4   = 4'(s_axis_tvalid);

    always_comb begin
        w_grant  = r_ptr;
        w_gvalid = 1'b0;
        if (r_state == RUN) begin
            if (STRICT) begin
                // Owed channel only; others wait even when valid.
                w_grant  = r_ptr;
                w_gvalid = 1'b1;
            end else begin
                w_grant  = first_from(w_en4 & w_vld4, r_ptr);
                w_gvalid = |(w_en4 & w_vld4);
            end
        end
    end

    assign w_rdy4   = (w_gvalid && w_room) ? (4'b0001 << w_grant) : 4'b0000;
    assign s_axis_tready = w_rdy4[NCH-1:0];
    assign w_accept = w_gvalid & w_room & w_vld4[w_grant];

    // The round ends when the next enabled channel wraps to or below grant;
    // in strict order this is exactly the highest enabled channel.
    assign w_next = first_from(w_en4, w_grant + 2'd1);
    assign w_last = (w_next <= w_grant);

    assign w_sel = s_axis_tdata[int'(w_grant)*DW +: DW];

    always_comb begin
        w_beat      = '0;
        w_beat.d    = sample_t'(w_sel);
        w_beat.id   = w_grant;
        w_beat.last = w_last;
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_en_nx    = r_en_q;
        unique case (r_state)
            IDLE: begin
                if (|ch_en) begin
                    w_state_nx = RUN;
                    w_en_nx    = ch_en;
                    w_ptr_nx   = first_from(w_ch_en4, 2'd0);
                end
            end
            RUN: begin
                if (w_accept) begin
                    w_ptr_nx = w_next;
                    // Mask changes only take effect between rounds.
                    if (w_last) begin
                        w_en_nx  = ch_en;
                        w_ptr_nx = first_from(w_ch_en4, 2'd0);
                        if (!(|ch_en)) begin
                            w_state_nx = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_en_q  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
            r_en_q  <= w_en_nx;
        end
    end

    axis_skid_buf #(
        .T (beat_t)
    ) u_skid (
        .i_clk   (s_axis_aclk),
        .i_rst_n (s_axis_aresetn),
        .i_data  (w_beat),
        .i_valid (w_accept),
        .o_room  (w_room),
        .o_data  (w_out),
        .o_valid (w_out_valid),
        .i_ready (m_axis_tready)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_round_cnt <= 32'd0;
        end else if (w_out_valid && m_axis_tready && w_out.last) begin
            r_round_cnt <= r_round_cnt + 32'd1;
        end
    end

    assign m_axis_tvalid = w_out_valid;
    assign m_axis_tdata  = w_out.d;
    assign m_axis_tuser  = w_out.id;
    assign m_axis_tlast  = w_out.last;
    assign round_cnt     = r_round_cnt;

endmodule

// File: tb/tb_demod_ch_arbiter.sv
// Bench for demod_ch_arbiter: strict (inst 0) and round-robin (inst 1)
// copies share control inputs and are checked by a transaction model.
module tb_demod_ch_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 24;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic [3:0] ch_en  = 4'h0;
    logic [3:0] tvalid = 4'h0;
    logic       m_ready = 1'b0;

    logic [NCH*DW-1:0] tdata   [2];
    logic [NCH-1:0]    tready  [2];
    logic [DW-1:0]     m_data  [2];
    logic [1:0]        m_user  [2];
    logic              m_last  [2];
    logic              m_valid [2];
    logic [31:0]       rcnt    [2];

    always #5 clk = ~clk;

    demod_ch_arbiter #(.NCH(NCH), .DW(DW), .STRICT(1'b1)) u_dut_s (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rstn),
        .ch_en          (ch_en),
        .s_axis_tdata   (tdata[0]),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready[0]),
        .m_axis_tdata   (m_data[0]),
        .m_axis_tuser   (m_user[0]),
        .m_axis_tlast   (m_last[0]),
        .m_axis_tvalid  (m_valid[0]),
        .m_axis_tready  (m_ready),
        .round_cnt      (rcnt[0])
    );

    demod_ch_arbiter #(.NCH(NCH), .DW(DW), .STRICT(1'b0)) u_dut_w (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rstn),
        .ch_en          (ch_en),
        .s_axis_tdata   (tdata[1]),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready[1]),
        .m_axis_tdata   (m_data[1]),
        .m_axis_tuser   (m_user[1]),
        .m_axis_tlast   (m_last[1]),
        .m_axis_tvalid  (m_valid[1]),
        .m_axis_tready  (m_ready),
        .round_cnt      (rcnt[1])
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] nx_en    = 4'h0;
    logic [3:0] nx_valid = 4'h0;
    logic       nx_ready = 1'b0;
    bit         rnd_valid = 0;
    bit         rnd_ready = 0;

    bit          m_run      [2];
    logic [3:0]  m_en       [2];
    int          m_ptr      [2];
    int          m_rounds   [2];
    int          k          [2][4];
    int          n_in       [2][4];
    int          n_out      [2];
    bit          stall_prev [2];
    bit          lat_pend   [2];
    logic [26:0] saved      [2];
    logic [26:0] q0 [$];
    logic [26:0] q1 [$];
    bit          rec = 0;
    int          rec_ch [$];

    function automatic int lowest(logic [3:0] m);
        for (int c = 0; c < 4; c++) if (m[c]) return c;
        return 0;
    endfunction

    function automatic int highest(logic [3:0] m);
        for (int c = 3; c >= 0; c--) if (m[c]) return c;
        return 0;
    endfunction

    function automatic int after(logic [3:0] m, int c);
        for (int d = 1; d <= 4; d++) if (m[(c + d) % 4]) return (c + d) % 4;
        return c;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(int i, logic [26:0] e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic q_pop(int i, output logic [26:0] e);
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i]      = 0;
            m_en[i]       = 4'h0;
            m_ptr[i]      = 0;
            m_rounds[i]   = 0;
            stall_prev[i] = 0;
            lat_pend[i]   = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic chk_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_tvalid", m_valid[i], 0);
            chk("rst_tdata", m_data[i], 0);
            chk("rst_tuser", m_user[i], 0);
            chk("rst_tlast", m_last[i], 0);
            chk("rst_tready", tready[i], 0);
            chk("rst_rounds", rcnt[i], 0);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, predict the posedge.
    task automatic step();
        logic [3:0]  rdy;
        logic [3:0]  hs;
        logic [26:0] e;
        logic [26:0] o;
        int          c;
        int          g;
        int          p;
        bit          last;
        bit          qe;
        @(negedge clk);
        ch_en   = nx_en;
        tvalid  = rnd_valid ? 4'($urandom_range(0, 15)) : nx_valid;
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : nx_ready;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++)
                tdata[i][j*DW +: DW] = DW'(16 * j + k[i][j]);
        #1;
        for (int i = 0; i < 2; i++) begin
            qe = 0;
            if (!m_run[i] && ch_en != 4'h0) begin
                m_run[i] = 1;
                m_en[i]  = ch_en;
                m_ptr[i] = lowest(ch_en);
            end
            rdy = tready[i];
            chk("rdy_onehot", $countones(rdy) <= 1, 1);
            if (!m_run[i]) begin
                chk("rdy_idle", rdy, 0);
            end else if (i == 0) begin
                chk("rdy_owed", rdy & ~(4'b0001 << m_ptr[i]), 0);
            end else if (rdy != 4'h0) begin
                g = -1;
                for (int d = 0; d < 4; d++) begin
                    p = (m_ptr[i] + d) % 4;
                    if (g < 0 && m_en[i][p] && tvalid[p]) g = p;
                end
                chk("rdy_rr", rdy, (g < 0) ? 4'h0 : (4'b0001 << g));
            end
            hs = rdy & tvalid;
            if (hs != 4'h0) begin
                c = lowest(hs);
                if (i == 0) last = (c == highest(m_en[i]));
                else        last = (after(m_en[i], c) <= c);
                e  = {DW'(16 * c + k[i][c]), 2'(c), last};
                qe = (q_size(i) == 0);
                q_push(i, e);
                k[i][c]++;
                n_in[i][c]++;
                if (rec && i == 0) rec_ch.push_back(c);
                m_ptr[i] = after(m_en[i], c);
                if (last) begin
                    if (ch_en == 4'h0) begin
                        m_run[i] = 0;
                        m_en[i]  = 4'h0;
                        m_ptr[i] = 0;
                    end else begin
                        m_en[i]  = ch_en;
                        m_ptr[i] = lowest(ch_en);
                    end
                end
            end
            o = {m_data[i], m_user[i], m_last[i]};
            chk("round_cnt", rcnt[i], m_rounds[i]);
            if (lat_pend[i]) chk("latency", m_valid[i], 1);
            if (stall_prev[i]) begin
                chk("hold_valid", m_valid[i], 1);
                chk("hold_beat", o, saved[i]);
            end
            stall_prev[i] = 0;
            if (m_valid[i] === 1'b1) begin
                if (m_ready) begin
                    chk("q_nonempty", q_size(i) > 0, 1);
                    if (q_size(i) > 0) begin
                        q_pop(i, e);
                        chk("beat_data", o[26:3], e[26:3]);
                        chk("beat_user", o[2:1], e[2:1]);
                        chk("beat_last", o[0], e[0]);
                        if (e[0]) m_rounds[i]++;
                        n_out[i]++;
                    end
                end else begin
                    stall_prev[i] = 1;
                    saved[i]      = o;
                end
            end
            lat_pend[i] = (hs != 4'h0) && qe;
        end
    endtask

    initial begin
        int steps;
        int snap0;
        int snap1;
        int base [4];
        int exp_seq [6];
        for (int i = 0; i < 2; i++) begin
            tdata[i] = '0;
            n_out[i] = 0;
            for (int j = 0; j < 4; j++) begin
                k[i][j]    = 0;
                n_in[i][j] = 0;
            end
        end
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_reset();

        // Strict cyclic order at full rate
        nx_en    = 4'hF;
        nx_valid = 4'hF;
        nx_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        steps = 0;
        while (n_out[0] < 100 && steps < 200) begin
            step();
            steps++;
        end
        chk("throughput", steps, 102);
        step();
        chk("rounds_100", rcnt[0], 25);

        // ch1 not valid for 5 clocks
        steps = 0;
        do begin
            step();
            steps++;
        end while (m_ptr[0] != 1 && steps < 8);
        chk("wait_ptr1", m_ptr[0], 1);
        snap0 = n_in[0][0] + n_in[0][1] + n_in[0][2] + n_in[0][3];
        snap1 = n_in[1][2] + n_in[1][3];
        nx_valid = 4'b1101;
        repeat (5) step();
        chk("strict_waits",
            n_in[0][0] + n_in[0][1] + n_in[0][2] + n_in[0][3] - snap0, 0);
        chk("rr_serves", (n_in[1][2] + n_in[1][3] - snap1) > 0, 1);
        nx_valid = 4'hF;
        repeat (12) step();

        // Random valid and random sink stalls
        for (int j = 0; j < 4; j++) base[j] = n_in[1][j];
        rnd_valid = 1;
        rnd_ready = 1;
        repeat (1000) step();
        rnd_valid = 0;
        rnd_ready = 0;
        for (int j = 0; j < 4; j++)
            chk("no_starve", (n_in[1][j] - base[j]) > 0, 1);
        nx_valid = 4'hF;
        nx_ready = 1'b1;
        repeat (10) step();

        // Enable mask change mid-round
        steps = 0;
        do begin
            step();
            steps++;
        end while (m_ptr[0] != 2 && steps < 8);
        chk("wait_ptr2", m_ptr[0], 2);
        nx_en = 4'h5;
        rec   = 1;
        rec_ch.delete();
        repeat (10) step();
        rec = 0;
        exp_seq = '{2, 3, 0, 2, 0, 2};
        chk("seq_len", rec_ch.size() >= 6, 1);
        for (int j = 0; j < 6; j++)
            if (j < rec_ch.size()) chk("seq_ch", rec_ch[j], exp_seq[j]);

        // Reset with the skid buffer full
        nx_en    = 4'hF;
        nx_ready = 1'b0;
        repeat (4) step();
        chk("skid_full_s", tready[0], 0);
        chk("skid_full_w", tready[1], 0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_reset();
        model_reset();
        @(negedge clk);
        rstn     = 1'b1;
        nx_ready = 1'b1;
        steps = 0;
        do begin
            step();
            steps++;
        end while (m_valid[0] !== 1'b1 && steps < 8);
        chk("post_rst_valid", m_valid[0], 1);
        chk("post_rst_user", m_user[0], 0);
        chk("post_rst_last", m_last[0], 0);
        repeat (10) step();

        // Disable all channels: drain and go idle
        nx_en = 4'h0;
        repeat (20) step();
        for (int i = 0; i < 2; i++) begin
            chk("idle_tready", tready[i], 0);
            chk("idle_tvalid", m_valid[i], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
